// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: turns a decoded MEM-stage op into one ready/valid
// bus transaction, stalls the pipeline meanwhile and returns extended load data.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [3:0]  rw_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  state_o
);

  // Handshake: a request is accepted in the cycle where mem_req_o and mem_gnt_i are
  // both high; read data is taken in any REQ/WAIT cycle with mem_rvalid_i high
  // (in REQ only together with the grant), and ignored in IDLE and DONE.

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q;
  logic [31:0]    addr_q, wdata_q, rdata_q;
  logic           err_q;
  logic [CW-1:0]  cnt_q;

  logic           aligned, go, store_q, complete, timeout_hit;
  logic [1:0]     size_q;
  logic [7:0]     byte_v;
  logic [15:0]    half_v;
  logic [31:0]    load_ext;

  function automatic logic is_store(input logic [3:0] op);
    return (op == 4'b1011) || (op == 4'b1110) || (op == 4'b1111);
  endfunction

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      4'b1001, 4'b1101, 4'b1110: return 2'd1;
      4'b1010, 4'b1111:          return 2'd2;
      default:                   return 2'd0;
    endcase
  endfunction

  always_comb begin
    case (op_size(rw_i))
      2'd1:    aligned = ~addr_i[0];
      2'd2:    aligned = (addr_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign go          = (state_q == S_IDLE) && req_valid_i && rw_i[3] && aligned;
  assign store_q     = is_store(op_q);
  assign size_q      = op_size(op_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // A load completes on read data, a store on its grant.
  always_comb begin
    complete = 1'b0;
    if (state_q == S_REQ)  complete = mem_gnt_i && (store_q || mem_rvalid_i);
    if (state_q == S_WAIT) complete = mem_rvalid_i;
  end

  // LBU/LHU carry op bit 2 set; the signed loads have it clear.
  assign byte_v = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
  assign half_v = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
  always_comb begin
    case (size_q)
      2'd0:    load_ext = op_q[2] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'd1:    load_ext = op_q[2] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (go) begin
        op_q    <= rw_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        cnt_q   <= '0;
      end else if (state_q == S_REQ || state_q == S_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Result registers hold a value only during the DONE cycle.
      if (state_d == S_DONE) begin
        rdata_q <= (complete && !store_q) ? load_ext : 32'd0;
        err_q   <= ~complete;
      end else begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (go) state_d = S_REQ;
      S_REQ: begin
        if (complete)                      state_d = S_DONE;
        else if (mem_gnt_i && !timeout_hit) state_d = S_WAIT;
        else if (timeout_hit)              state_d = S_DONE;
      end
      S_WAIT: if (complete || timeout_hit) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o    = (state_q == S_REQ);
    mem_we_o     = 1'b0;
    mem_addr_o   = 32'd0;
    mem_wstrb_o  = 4'b0000;
    mem_wdata_o  = 32'd0;
    stall_o      = (state_q == S_REQ) || (state_q == S_WAIT) || go;
    done_o       = (state_q == S_DONE);
    misaligned_o = (state_q == S_IDLE) && req_valid_i && rw_i[3] && !aligned;
    rdata_o      = rdata_q;
    bus_err_o    = err_q;
    state_o      = state_q;
    if (state_q == S_REQ) begin
      mem_addr_o = {addr_q[31:2], 2'b00};
      if (store_q) begin
        mem_we_o = 1'b1;
        case (size_q)
          2'd0: begin
            mem_wstrb_o = 4'b0001 << addr_q[1:0];
            mem_wdata_o = {4{wdata_q[7:0]}};
          end
          2'd1: begin
            mem_wstrb_o = addr_q[1] ? 4'b1100 : 4'b0011;
            mem_wdata_o = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_wstrb_o = 4'b1111;
            mem_wdata_o = wdata_q;
          end
        endcase
      end
    end
  end

endmodule
